riscv_hazard_ctrl: RTL and testbench
====================================

Name: riscv_hazard_ctrl

Overview:
- Issue/hazard controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Decides every cycle whether the instruction in ID may issue to EX:
  - keeps a 32-entry register scoreboard;
  - sequences multi-cycle MUL/DIV occupancy of EX;
  - generates the flush/redirect bubbles after a taken BEQ.
- Drives the stall and flush enables of the IF/ID and ID/EX pipeline registers, plus a stall performance counter.

Parameters:
- MUL_LAT, 3, EX cycles occupied by MUL (≥1).
- DIV_LAT, 8, EX cycles occupied by DIV (≥1).
- BR_BUBBLES, 1, cycles after a taken-branch flush during which ID is ignored (0..3).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- id_valid  input  1  IF/ID holds a valid instruction.
- id_ir  input  32  instruction in IF/ID.
- ex_br_valid  input  1  BEQ in EX this cycle, condition resolved.
- ex_br_taken  input  1  BEQ condition true (qualified by ex_br_valid).
- wb_valid  input  1  WB writes a register this cycle.
- wb_rd  input  5  register written by WB.
- issue  output  1  ID instruction moves to EX this cycle.
- stall_if  output  1  hold PC and IF/ID.
- stall_id  output  1  hold IF/ID, insert NOP into ID/EX.
- ex_hold  output  1  hold ID/EX and the EX operation (MUL/DIV in progress).
- flush_if_id  output  1  clear IF/ID to NOP (taken branch).
- busy_reg  output  32  scoreboard: bit n = write to Rn pending.
- stall_count  output  16  saturating count of cycles with stall_id=1.

Behaviour:
- Decode, from id_ir:
  - op = [6:0], f3 = [14:12], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
  - op 0 = ARITH, 1 = LOGICAL, 2 = LOAD_STORE, 3 = BRANCH. Any other op: treated as NOP, never stalls, writes nothing.
- Source registers used:
  - ARITH f3 0..3: rs1, rs2. ARITH f3 4,5: rs1 only.
  - LOGICAL: rs1, rs2.
  - LOAD_STORE f3=0 (SDW): rs1, rs2, rd. LOAD_STORE f3=1 (LDW): rs1, rs2.
  - BRANCH: rs1, rd.
- Writers: ARITH, LOGICAL, LDW write rd. R0 is hard zero: never marked busy, never causes a hazard.
- Hazard = id_valid and any used source, or the writer's rd, has its busy_reg bit set (RAW and WAW both stall). No forwarding: the consumer waits until the producer's WB clears the bit.
- Scoreboard:
  - On issue of a writer, busy_reg[rd] is set at the next edge.
  - wb_valid clears busy_reg[wb_rd] at the next edge.
  - Same-register set and clear in the same cycle: set wins.
  - A clear in cycle N is visible to the hazard check in cycle N+1; no same-cycle bypass.
- FSM states: RUN, EXBUSY, REDIRECT.
  - RUN: issue = id_valid & ~hazard & ~flush. On issue of MUL (ARITH f3=2) or DIV (f3=3) with LAT>1, load cnt = LAT-1 and go to EXBUSY.
  - EXBUSY: ex_hold = stall_if = stall_id = 1, issue = 0, cnt decrements each cycle; cnt==1 → RUN next cycle. MUL occupies EX for exactly MUL_LAT cycles; DIV likewise with DIV_LAT.
  - Taken branch (ex_br_valid & ex_br_taken), from RUN only:
    - flush_if_id = 1 for one cycle; issue = 0 that cycle (the ID instruction is killed and does not set the scoreboard).
    - If BR_BUBBLES > 0: go to REDIRECT for BR_BUBBLES cycles, with issue = 0 and stall_id = 0 (ID/EX receives NOPs, IF runs), then RUN.
  - ex_br_valid in EXBUSY or REDIRECT cannot occur; ignore it.
  - A not-taken branch has no effect.
- Stall output rules:
  - stall_id = stall_if = id_valid & hazard & state==RUN, or state==EXBUSY.
  - Flush takes priority over hazard: during the flush cycle stall_* = 0.
- stall_count increments on each cycle with stall_id=1 and saturates at 16'hFFFF.
- Outputs are combinational from state and inputs; busy_reg, stall_count and the FSM are registered.
- Reset (asynchronous, any time including mid-DIV or mid-REDIRECT):
  - state = RUN, cnt = 0, busy_reg = 0, stall_count = 0.
  - Outputs follow: issue = id_valid & ~hazard, with hazard = 0.

Test Plan:
- Stall on RAW: issue add r3,r1,r2 (32'h00208180), next ID and r4,r3,r2 (32'h00218201) → stall_id=1 until WB pulses wb_rd=3; issue=1 the cycle after; stall_count equals the stall cycle count.
- R0 and WAW: write to r0 issued twice back-to-back → no stall, busy_reg[0] stays 0. Two writes to r5 → second stalls until the first retires.
- Multi-cycle divide: DIV issued with DIV_LAT=8 → ex_hold=1 for exactly 7 cycles after the issue cycle, issue=0 throughout, RUN resumes on cycle 8.
- Taken branch: ex_br_valid=1, ex_br_taken=1 with a hazard-free ID instruction → flush_if_id=1 one cycle, issue=0, busy_reg unchanged, one REDIRECT cycle, then issue resumes. Not-taken → no flush.
- Simultaneous set and clear: issue a writer to r7 in the same cycle wb_rd=7 → busy_reg[7]=1 afterwards.
- Reset mid-DIV: assert reset at cnt=4 → immediately ex_hold=0, busy_reg=0, stall_count=0; after release, state RUN.

Source files
------------

// File: rtl/riscv_hazard_ctrl.sv
// Issue/hazard controller for the 5-stage core: register scoreboard, MUL/DIV
// EX occupancy sequencing and taken-branch flush/redirect bubbles.
module riscv_hazard_ctrl #(
  parameter int MUL_LAT    = 3,
  parameter int DIV_LAT    = 8,
  parameter int BR_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_ir,
  input  logic        ex_br_valid,
  input  logic        ex_br_taken,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        issue,
  output logic        stall_if,
  output logic        stall_id,
  output logic        ex_hold,
  output logic        flush_if_id,
  output logic [31:0] busy_reg,
  output logic [15:0] stall_count
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_MAX = (LAT_MAX > BR_BUBBLES) ? LAT_MAX : BR_BUBBLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {RUN, EXBUSY, REDIRECT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [31:0]     busy_next;
  logic [31:0]     src_mask;

  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic       use_rs1, use_rs2, use_rd, writes_rd, is_mul, is_div;
  logic       hazard, br_flush, stall, set_en;
  logic       unused_ir;

  assign op        = id_ir[6:0];
  assign rd        = id_ir[11:7];
  assign f3        = id_ir[14:12];
  assign rs1       = id_ir[19:15];
  assign rs2       = id_ir[24:20];
  assign unused_ir = ^id_ir[31:25];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    writes_rd = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    case (op)
      7'd0: begin
        use_rs1   = 1'b1;
        use_rs2   = (f3 <= 3'd3);
        writes_rd = 1'b1;
        is_mul    = (f3 == 3'd2);
        is_div    = (f3 == 3'd3);
      end
      7'd1: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      7'd2: begin
        use_rs1   = (f3 == 3'd0) || (f3 == 3'd1);
        use_rs2   = (f3 == 3'd0) || (f3 == 3'd1);
        use_rd    = (f3 == 3'd0);
        writes_rd = (f3 == 3'd1);
      end
      7'd3: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      default: ;
    endcase
  end

  // R0 never appears in the source mask and never becomes busy.
  assign src_mask[0]  = 1'b0;
  assign busy_next[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      assign src_mask[gi] = (use_rs1 && rs1 == 5'(gi)) ||
                            (use_rs2 && rs2 == 5'(gi)) ||
                            ((use_rd || writes_rd) && rd == 5'(gi));
      assign busy_next[gi] = (set_en && rd == 5'(gi)) ||
                             (busy_reg[gi] && !(wb_valid && wb_rd == 5'(gi)));
    end
  endgenerate

  assign hazard   = id_valid && |(src_mask & busy_reg);
  assign br_flush = (state_reg == RUN) && ex_br_valid && ex_br_taken;
  assign set_en   = issue && writes_rd;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    issue       = 1'b0;
    stall       = 1'b0;
    ex_hold     = 1'b0;
    flush_if_id = 1'b0;
    case (state_reg)
      RUN: begin
        if (br_flush) begin
          flush_if_id = 1'b1;
          if (BR_BUBBLES > 0) begin
            state_next = REDIRECT;
            cnt_next   = CW'(BR_BUBBLES);
          end
        end else if (hazard) begin
          stall = 1'b1;
        end else if (id_valid) begin
          issue = 1'b1;
          if (is_mul && MUL_LAT > 1) begin
            state_next = EXBUSY;
            cnt_next   = CW'(MUL_LAT - 1);
          end else if (is_div && DIV_LAT > 1) begin
            state_next = EXBUSY;
            cnt_next   = CW'(DIV_LAT - 1);
          end
        end
      end
      EXBUSY: begin
        ex_hold  = 1'b1;
        stall    = 1'b1;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) state_next = RUN;
      end
      REDIRECT: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) state_next = RUN;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  assign stall_id = stall;
  assign stall_if = stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      busy_reg    <= '0;
      stall_count <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl: directed scenarios plus random
// traffic, compared cycle by cycle against a behavioural occupancy model.
module tb_riscv_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam int BRB     = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_ir;
  logic        ex_br_valid, ex_br_taken;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        issue, stall_if, stall_id, ex_hold, flush_if_id;
  logic [31:0] busy_reg;
  logic [15:0] stall_count;

  riscv_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .BR_BUBBLES(BRB)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ir(id_ir),
    .ex_br_valid(ex_br_valid), .ex_br_taken(ex_br_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .stall_if(stall_if), .stall_id(stall_id), .ex_hold(ex_hold),
    .flush_if_id(flush_if_id), .busy_reg(busy_reg), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending writes as a bit set, EX occupancy and redirect
  // bubbles as "cycles remaining" counts.
  bit [31:0] m_busy;
  int        ex_left, bub_left, m_count;
  bit        e_issue, e_stall, e_hold, e_flush;

  function automatic [31:0] mk(input int op, input int f3, input int rd, input int rs1, input int rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
  endfunction

  // Returns registers read/written as a mask (R0 excluded), writer flag and latency.
  task automatic decode(input [31:0] ir, output bit [31:0] srcs, output bit wr, output int lat);
    int op, f3, rd, r1, r2;
    op = int'(ir[6:0]); f3 = int'(ir[14:12]); rd = int'(ir[11:7]);
    r1 = int'(ir[19:15]); r2 = int'(ir[24:20]);
    srcs = 0; wr = 0; lat = 1;
    if (op == 0) begin
      srcs[r1] = 1; if (f3 <= 3) srcs[r2] = 1; srcs[rd] = 1; wr = 1;
      if (f3 == 2) lat = MUL_LAT;
      if (f3 == 3) lat = DIV_LAT;
    end else if (op == 1) begin
      srcs[r1] = 1; srcs[r2] = 1; srcs[rd] = 1; wr = 1;
    end else if (op == 2 && f3 <= 1) begin
      srcs[r1] = 1; srcs[r2] = 1; srcs[rd] = 1; wr = (f3 == 1);
    end else if (op == 3) begin
      srcs[r1] = 1; srcs[rd] = 1;
    end
    srcs[0] = 0;
  endtask

  task automatic cycle(input bit v, input [31:0] ir, input bit brv, input bit brt,
                       input bit wbv, input [4:0] wrd);
    bit [31:0] srcs;
    bit        wr, hz;
    int        lat;
    @(negedge clk);
    id_valid = v; id_ir = ir; ex_br_valid = brv; ex_br_taken = brt;
    wb_valid = wbv; wb_rd = wrd;
    #2;
    decode(ir, srcs, wr, lat);
    hz = v && ((srcs & m_busy) != 0);
    e_issue = 0; e_stall = 0; e_hold = 0; e_flush = 0;
    if (ex_left > 0) begin
      e_stall = 1; e_hold = 1;
    end else if (bub_left == 0) begin
      e_flush = brv && brt;
      e_stall = !e_flush && hz;
      e_issue = !e_flush && v && !hz;
    end
    $display("cyc t=%0t v=%0d ir=%h br=%0d%0d wb=%0d/%0d -> issue=%0d stall=%0d hold=%0d flush=%0d busy=%h cnt=%0d",
             $time, v, ir, brv, brt, wbv, wrd, issue, stall_id, ex_hold, flush_if_id, busy_reg, stall_count);
    check_val("issue", 32'(issue), 32'(e_issue));
    check_val("stall_id", 32'(stall_id), 32'(e_stall));
    check_val("stall_if", 32'(stall_if), 32'(e_stall));
    check_val("ex_hold", 32'(ex_hold), 32'(e_hold));
    check_val("flush_if_id", 32'(flush_if_id), 32'(e_flush));
    check_val("busy_reg", busy_reg, m_busy);
    check_val("stall_count", 32'(stall_count), 32'(m_count));
    @(posedge clk);
    if (wbv) m_busy[wrd] = 0;
    if (e_issue && wr && ir[11:7] != 0) m_busy[ir[11:7]] = 1;
    if (e_stall && m_count < 65535) m_count++;
    if (ex_left > 0) ex_left--;
    else if (bub_left > 0) bub_left--;
    else if (e_flush) bub_left = BRB;
    else if (e_issue && lat > 1) ex_left = lat - 1;
  endtask

  task automatic do_reset();
    id_valid = 0; ex_br_valid = 0; ex_br_taken = 0; wb_valid = 0; wb_rd = 0;
    #3 reset = 1;
    #1;
    m_busy = 0; ex_left = 0; bub_left = 0; m_count = 0;
    $display("reset t=%0t hold=%0d busy=%h cnt=%0d", $time, ex_hold, busy_reg, stall_count);
    check_val("rst_ex_hold", 32'(ex_hold), 0);
    check_val("rst_busy", busy_reg, 0);
    check_val("rst_count", 32'(stall_count), 0);
    check_val("rst_stall", 32'(stall_id), 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    bit [31:0] add313, and413, div6;
    add313 = mk(0, 0, 3, 1, 2);
    and413 = mk(1, 0, 4, 3, 2);
    div6   = mk(0, 3, 6, 1, 2);
    m_busy = 0; ex_left = 0; bub_left = 0; m_count = 0;

    // Reset state with a hazard-free instruction presented
    reset = 1; id_valid = 1; id_ir = add313; ex_br_valid = 0; ex_br_taken = 0;
    wb_valid = 0; wb_rd = 0;
    #2;
    check_val("init_issue", 32'(issue), 1);
    check_val("init_stall", 32'(stall_id), 0);
    check_val("init_busy", busy_reg, 0);
    check_val("init_count", 32'(stall_count), 0);
    #6 reset = 0;

    // RAW stall released by WB of r3
    cycle(1, add313, 0, 0, 0, 0);
    repeat (3) cycle(1, and413, 0, 0, 0, 0);
    cycle(1, and413, 0, 0, 1, 3);
    cycle(1, and413, 0, 0, 0, 0);
    check_val("raw_count", 32'(stall_count), 4);

    // R0 writes never busy; WAW on r5
    do_reset();
    cycle(1, mk(0, 0, 0, 1, 2), 0, 0, 0, 0);
    cycle(1, mk(1, 0, 0, 1, 2), 0, 0, 0, 0);
    check_val("r0_busy", 32'(busy_reg[0]), 0);
    cycle(1, mk(0, 0, 5, 1, 2), 0, 0, 0, 0);
    repeat (2) cycle(1, mk(0, 1, 5, 1, 2), 0, 0, 0, 0);
    cycle(1, mk(0, 1, 5, 1, 2), 0, 0, 1, 5);
    cycle(1, mk(0, 1, 5, 1, 2), 0, 0, 0, 0);

    // DIV occupancy then MUL occupancy
    do_reset();
    cycle(1, div6, 0, 0, 0, 0);
    repeat (8) cycle(1, mk(0, 0, 9, 1, 2), 0, 0, 0, 0);
    cycle(1, mk(0, 2, 10, 1, 2), 0, 0, 0, 0);
    repeat (3) cycle(1, mk(1, 0, 11, 1, 2), 0, 0, 0, 0);

    // Taken branch, then not-taken branch
    do_reset();
    cycle(1, add313, 1, 1, 0, 0);
    cycle(1, add313, 0, 0, 0, 0);
    cycle(1, add313, 0, 0, 0, 0);
    cycle(1, mk(0, 0, 12, 1, 2), 1, 0, 0, 0);

    // Simultaneous set and clear of r7
    do_reset();
    cycle(1, mk(0, 0, 7, 1, 2), 0, 0, 1, 7);
    cycle(0, 0, 0, 0, 0, 0);
    check_val("r7_set_wins", 32'(busy_reg[7]), 1);

    // Reset in the middle of a divide (cnt = 4)
    do_reset();
    cycle(1, div6, 0, 0, 0, 0);
    repeat (3) cycle(1, add313, 0, 0, 0, 0);
    do_reset();
    cycle(1, add313, 0, 0, 0, 0);

    // Random traffic over a small register window
    for (int n = 0; n < 500; n++) begin
      int  op, f3;
      bit  brv, wbv;
      op = int'($urandom_range(0, 5));
      if (op == 0) f3 = int'($urandom_range(0, 5));
      else if (op == 2) f3 = int'($urandom_range(0, 1));
      else f3 = int'($urandom_range(0, 7));
      brv = (ex_left == 0 && bub_left == 0) && ($urandom_range(0, 9) == 0);
      wbv = ($urandom_range(0, 2) == 0);
      cycle(1'($urandom_range(0, 3) != 0),
            mk(op, f3, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))),
            brv, 1'($urandom_range(0, 1)), wbv, 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
